// File: rtl/score_uart_pkg.sv
// Shared constants, types and byte formatter for the score report transmitter.
// SCORE_UART_TX_PARITY_EN selects the 11-bit even-parity frame.
package score_uart_pkg;

   localparam logic [7:0] CH_G     = 8'h47;
   localparam logic [7:0] CH_DASH  = 8'h2D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_QMARK = 8'h3F;
   localparam logic [7:0] CH_ZERO  = 8'h30;

   localparam int unsigned MSG_LEN = 10;

`ifdef SCORE_UART_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif

   localparam logic [1:0] SIDE_P1 = 2'b01;
   localparam logic [1:0] SIDE_P2 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_NEXT
   } msg_state_e;

   typedef struct packed {
      logic [1:0] side;
      logic [3:0] p1_dig1;
      logic [3:0] p1_dig0;
      logic [3:0] p2_dig1;
      logic [3:0] p2_dig0;
   } score_msg_t;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return (d > 4'd9) ? CH_QMARK : (CH_ZERO + {4'h0, d});
   endfunction

   function automatic logic [7:0] msg_byte(input score_msg_t m, input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = CH_G;
         4'd1:    b = (m.side == SIDE_P2) ? (CH_ZERO + 8'd2) : (CH_ZERO + 8'd1);
         4'd2:    b = CH_SPACE;
         4'd3:    b = digit_char(m.p1_dig1);
         4'd4:    b = digit_char(m.p1_dig0);
         4'd5:    b = CH_DASH;
         4'd6:    b = digit_char(m.p2_dig1);
         4'd7:    b = digit_char(m.p2_dig0);
         4'd8:    b = CH_CR;
         default: b = CH_LF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/score_uart_tx_if.sv
// Scoring event and status bundle between the game FSM and the report transmitter.
interface score_uart_tx_if;
   logic       goal_valid;
   logic [1:0] goal_side;
   logic [3:0] p1_dig1;
   logic [3:0] p1_dig0;
   logic [3:0] p2_dig1;
   logic [3:0] p2_dig0;
   logic       busy;
   logic [7:0] drop_cnt;

   modport master (
      output goal_valid, goal_side, p1_dig1, p1_dig0, p2_dig1, p2_dig0,
      input  busy, drop_cnt
   );

   modport slave (
      input  goal_valid, goal_side, p1_dig1, p1_dig0, p2_dig1, p2_dig0,
      output busy, drop_cnt
   );
endinterface

// File: rtl/uart_tx_byte.sv
// One-byte UART serializer: start, 8 data bits LSB first, optional even parity
// (SCORE_UART_TX_PARITY_EN), stop. Baud counter restarts on every start.
module uart_tx_byte
   import score_uart_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int unsigned    CW        = $clog2(DIV);
   localparam int unsigned    SW        = FRAME_BITS - 1;
   localparam logic [CW-1:0]  TICK_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0]  TICK_PRE  = CW'(DIV - 2);
   localparam logic [3:0]     BIT_LAST  = 4'(FRAME_BITS - 1);

   logic          active_q, active_d;
   logic          tx_q, tx_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [SW-1:0] shift_q, shift_d;
   logic [SW-1:0] frame_load;

`ifdef SCORE_UART_TX_PARITY_EN
   assign frame_load = {1'b1, ^data, data};
`else
   assign frame_load = {1'b1, data};
`endif

   always_comb begin
      active_d = active_q;
      tx_d     = tx_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      if (start) begin
         active_d = 1'b1;
         tx_d     = 1'b0;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = frame_load;
      end else if (active_q) begin
         if (baud_q == TICK_LAST) begin
            baud_d = '0;
            if (bit_q == BIT_LAST) begin
               active_d = 1'b0;
            end else begin
               tx_d    = shift_q[0];
               shift_d = {1'b1, shift_q[SW-1:1]};
               bit_d   = bit_q + 4'd1;
            end
         end else begin
            baud_d = baud_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= 1'b0;
         tx_q     <= 1'b1;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
      end else begin
         active_q <= active_d;
         tx_q     <= tx_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
      end
   end

   assign tx = tx_q;
   // Fires one cycle before the stop bit ends so the caller's start lands on the
   // first cycle after the stop bit, leaving no gap between bytes.
   assign done = active_q && (bit_q == BIT_LAST) && (baud_q == TICK_PRE);

endmodule

// File: rtl/score_uart_tx.sv
// Score report transmitter: snapshots scoring events into two message slots and
// sends each as a 10-byte ASCII line over RsTx (parity via SCORE_UART_TX_PARITY_EN).
module score_uart_tx
   import score_uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic                  clk,
   input  logic                  reset_n,
   score_uart_tx_if.slave        ev,
   output logic                  RsTx
);

   localparam int unsigned DIV      = CLK_HZ / BAUD;
   localparam logic [3:0]  IDX_LAST = 4'(MSG_LEN - 1);

   msg_state_e state_q, state_d;
   logic [3:0] idx_q, idx_d;
   score_msg_t act_q, act_d, pend_q, pend_d;
   logic       act_valid_q, act_valid_d;
   logic       pend_valid_q, pend_valid_d;
   logic [7:0] drop_q, drop_d;

   logic       legal;
   logic       ser_start;
   logic       ser_done;
   score_msg_t incoming;

   assign legal    = ev.goal_valid && ((ev.goal_side == SIDE_P1) || (ev.goal_side == SIDE_P2));
   assign incoming = '{side:    ev.goal_side,
                       p1_dig1: ev.p1_dig1,
                       p1_dig0: ev.p1_dig0,
                       p2_dig1: ev.p2_dig1,
                       p2_dig0: ev.p2_dig0};
   assign ser_start = (state_q == ST_LOAD);

   always_comb begin
      act_d        = act_q;
      act_valid_d  = act_valid_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      drop_d       = drop_q;
      state_d      = state_q;
      idx_d        = idx_q;

      // Slot hand-over is resolved first so a coincident event sees the freed slot.
      if (state_q == ST_NEXT) begin
         if (pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
         end else begin
            act_valid_d = 1'b0;
         end
      end

      if (legal) begin
         if (!act_valid_d) begin
            act_d       = incoming;
            act_valid_d = 1'b1;
         end else if (!pend_valid_d) begin
            pend_d       = incoming;
            pend_valid_d = 1'b1;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (act_valid_q) begin
               state_d = ST_LOAD;
               idx_d   = '0;
            end
         end
         ST_LOAD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (ser_done) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_NEXT;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_NEXT: begin
            idx_d   = '0;
            state_d = act_valid_d ? ST_LOAD : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         act_q        <= '0;
         pend_q       <= '0;
         act_valid_q  <= 1'b0;
         pend_valid_q <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         act_q        <= act_d;
         pend_q       <= pend_d;
         act_valid_q  <= act_valid_d;
         pend_valid_q <= pend_valid_d;
         drop_q       <= drop_d;
      end
   end

   uart_tx_byte #(.DIV(DIV)) u_ser (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (ser_start),
      .data    (msg_byte(act_q, idx_q)),
      .tx      (RsTx),
      .done    (ser_done)
   );

   assign ev.busy     = act_valid_q | pend_valid_q;
   assign ev.drop_cnt = drop_q;

endmodule

// File: tb/tb_score_uart_tx.sv
// Scoreboard bench for score_uart_tx: stimulus queues expected bytes, a line
// monitor decodes RsTx frames and checks them against the queue.
module tb_score_uart_tx;

   localparam int unsigned DIV = 10;
`ifdef SCORE_UART_TX_PARITY_EN
   localparam int unsigned FRAME = 11;
`else
   localparam int unsigned FRAME = 10;
`endif
   localparam int unsigned MSG_CYC = 10 * FRAME * DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic RsTx;

   score_uart_tx_if ifc();

   score_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ev      (ifc),
      .RsTx    (RsTx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic push_msg(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   // Called just after a rising edge; the event is captured on the next edge.
   task automatic send_event(input logic [1:0] side, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
      ifc.goal_side  = side;
      ifc.p1_dig1    = a;
      ifc.p1_dig0    = b;
      ifc.p2_dig1    = c;
      ifc.p2_dig0    = d;
      ifc.goal_valid = 1'b1;
      @(posedge clk);
      #1 ifc.goal_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (ifc.busy && n < max_cyc) begin
         @(posedge clk);
         #1 n++;
      end
      chk("idle_timeout", {31'd0, ifc.busy}, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   initial begin : monitor
      logic [10:0] bits;
      logic        lvl;
      logic        stable;
      logic        aborted;
      logic [7:0]  want;
      forever begin
         @(negedge clk);
         if (reset_n && RsTx == 1'b0) begin
            bits    = '1;
            stable  = 1'b1;
            aborted = 1'b0;
            lvl     = 1'b0;
            for (int b = 0; b < FRAME; b++) begin
               for (int k = 0; k < DIV; k++) begin
                  if (!(b == 0 && k == 0)) @(negedge clk);
                  if (!reset_n) aborted = 1'b1;
                  if (aborted) break;
                  if (k == 0) begin
                     lvl     = RsTx;
                     bits[b] = RsTx;
                  end else if (RsTx !== lvl) begin
                     stable = 1'b0;
                  end
               end
               if (aborted) break;
            end
            if (!aborted) begin
               chk("frame_shape", {29'd0, stable, bits[0], bits[FRAME-1]}, 32'd5);
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
               end else begin
                  want = exp_q.pop_front();
                  chk("rx_byte", {24'd0, bits[8:1]}, {24'd0, want});
`ifdef SCORE_UART_TX_PARITY_EN
                  chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^want});
`endif
               end
            end
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      int toggles;
      logic prev;
      ifc.goal_valid = 1'b0;
      ifc.goal_side  = 2'b00;
      ifc.p1_dig1    = 4'd0;
      ifc.p1_dig0    = 4'd0;
      ifc.p2_dig1    = 4'd0;
      ifc.p2_dig0    = 4'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", {31'd0, RsTx}, 32'd1);
      chk("reset_busy", {31'd0, ifc.busy}, 32'd0);
      chk("reset_drop", {24'd0, ifc.drop_cnt}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single event: latency of busy and start bit, then message length.
      push_msg("G1 03-12\r\n");
      send_event(2'b01, 4'd0, 4'd3, 4'd1, 4'd2);
      chk("busy_rise", {31'd0, ifc.busy}, 32'd1);
      chk("tx_capture_edge", {31'd0, RsTx}, 32'd1);
      @(posedge clk);
      #1 chk("tx_edge1", {31'd0, RsTx}, 32'd1);
      @(posedge clk);
      #1 chk("tx_edge2_start", {31'd0, RsTx}, 32'd0);
      n = 0;
      while (ifc.busy && n < int'(MSG_CYC) + 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("busy_fall_cycles", n, MSG_CYC);
      chk("single_drained", exp_q.size(), 32'd0);

      // Illegal side codes are ignored.
      send_event(2'b11, 4'd1, 4'd1, 4'd1, 4'd1);
      chk("illegal_11_busy", {31'd0, ifc.busy}, 32'd0);
      send_event(2'b00, 4'd1, 4'd1, 4'd1, 4'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("illegal_00_busy", {31'd0, ifc.busy}, 32'd0);
      chk("illegal_tx_idle", {31'd0, RsTx}, 32'd1);

      // Illegal BCD digit becomes '?'.
      push_msg("G2 03-1?\r\n");
      send_event(2'b10, 4'd0, 4'd3, 4'd1, 4'hC);
      wait_idle(MSG_CYC + 100);

      // Full buffer: third event five cycles later is dropped.
      push_msg("G1 04-12\r\n");
      push_msg("G2 04-13\r\n");
      send_event(2'b01, 4'd0, 4'd4, 4'd1, 4'd2);
      repeat (4) @(posedge clk);
      #1 send_event(2'b10, 4'd0, 4'd4, 4'd1, 4'd3);
      repeat (4) @(posedge clk);
      #1 send_event(2'b01, 4'd0, 4'd5, 4'd1, 4'd3);
      chk("drop_after_third", {24'd0, ifc.drop_cnt}, 32'd1);
      wait_idle(2 * MSG_CYC + 100);
      chk("drop_final", {24'd0, ifc.drop_cnt}, 32'd1);

      // Hand-over collision: C lands on the edge where B moves to active.
      push_msg("G1 05-13\r\n");
      push_msg("G2 05-14\r\n");
      push_msg("G1 06-14\r\n");
      send_event(2'b01, 4'd0, 4'd5, 4'd1, 4'd3);
      repeat (2) @(posedge clk);
      #1 send_event(2'b10, 4'd0, 4'd5, 4'd1, 4'd4);
      repeat (MSG_CYC - 2) @(posedge clk);
      #1 chk("pre_handover_busy", {31'd0, ifc.busy}, 32'd1);
      send_event(2'b01, 4'd0, 4'd6, 4'd1, 4'd4);
      chk("handover_drop", {24'd0, ifc.drop_cnt}, 32'd1);
      wait_idle(3 * MSG_CYC + 100);

      // Reset during D3 of the 4th byte ('0' = 8'h30, D3 = 0).
      push_msg("G1 07-14\r\n");
      send_event(2'b01, 4'd0, 4'd7, 4'd1, 4'd4);
      repeat (1 + 3 * FRAME * DIV + 4 * DIV + 5) @(posedge clk);
      #1 chk("pre_reset_d3", {31'd0, RsTx}, 32'd0);
      #1 reset_n = 1'b0;
      #1;
      chk("reset_tx_immediate", {31'd0, RsTx}, 32'd1);
      chk("reset_busy_immediate", {31'd0, ifc.busy}, 32'd0);
      chk("reset_drop_immediate", {24'd0, ifc.drop_cnt}, 32'd0);
      repeat (3) @(posedge clk);
      #1 chk("bytes_before_reset", exp_q.size(), 32'd7);
      exp_q.delete();
      reset_n = 1'b1;
      toggles = 0;
      prev = RsTx;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (RsTx !== prev) toggles++;
         prev = RsTx;
      end
      chk("post_reset_toggles", toggles, 32'd0);
      chk("post_reset_busy", {31'd0, ifc.busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
